neuron_mac_controller: RTL and testbench
========================================

NEURON_MAC_CONTROLLER -- requirements
Module: neuron_mac_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed width of inputs, weights, bias and result.
REQ-002 SHALL have parameter ACC_WIDTH, default 40: signed accumulator width; must be >= 2*DATA_WIDTH + clog2(NUM_INPUTS).
REQ-003 SHALL have parameter NUM_INPUTS, default 8: number of input/weight pairs per neuron evaluation; must be >= 1.
REQ-004 SHALL have parameter FRAC_BITS, default 8: fractional bits of the fixed-point format.
REQ-005 SHALL have port clk_in, input, 1 bit: the only clock; all logic is rising-edge triggered.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start_in, input, 1 bit: begin an evaluation; sampled only in IDLE.
REQ-008 SHALL have port bias_in, input, DATA_WIDTH bits, signed: bias, captured on the accepted start cycle.
REQ-009 SHALL have port in_valid_in, input, 1 bit: input_in and weight_in carry a valid pair.
REQ-010 SHALL have port in_ready_out, output, 1 bit: controller accepts a pair this cycle.
REQ-011 SHALL have port input_in, input, DATA_WIDTH bits, signed: activation operand.
REQ-012 SHALL have port weight_in, input, DATA_WIDTH bits, signed: weight operand.
REQ-013 SHALL have port out_valid_out, output, 1 bit: result_out is valid.
REQ-014 SHALL have port out_ready_in, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port result_out, output, DATA_WIDTH bits, signed: saturated neuron output.
REQ-016 SHALL have port busy_out, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM, SCALE, SATURATE and OUTPUT.
REQ-018 IDLE: when start_in=1, SHALL load the accumulator with bias_in sign-extended and shifted left by FRAC_BITS, clear the pair counter, and go to ACCUM on the next cycle.
REQ-019 ACCUM: in_ready_out SHALL be 1; a pair is accepted only when in_valid_in and in_ready_out are both 1.
REQ-020 Each accepted pair SHALL add its full-precision 2*DATA_WIDTH signed product to the accumulator and increment the counter.
REQ-021 The accumulate in REQ-020 SHALL use no rounding and no intermediate saturation.
REQ-022 When the NUM_INPUTS-th pair is accepted, the FSM SHALL go to SCALE; in_ready_out SHALL be 0 in every state other than ACCUM.
REQ-023 Cycles in ACCUM with in_valid_in=0 SHALL be stalls: counter and accumulator hold.
REQ-024 SCALE SHALL register the accumulator arithmetically shifted right by FRAC_BITS (truncation toward minus infinity), then go to SATURATE.
REQ-025 SATURATE SHALL pass the scaled value through the saturation sub-module and register the clamped result into result_out, then go to OUTPUT.
REQ-026 Clamp bounds SHALL be [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1].
REQ-027 OUTPUT: out_valid_out SHALL be 1 and result_out SHALL be stable until out_ready_in=1; on that handshake the FSM SHALL go to IDLE.
REQ-028 Latency SHALL be 3 cycles from acceptance of the last pair to out_valid_out=1 (SCALE, SATURATE, then OUTPUT visible).
REQ-029 start_in asserted outside IDLE SHALL be ignored; no queuing.
REQ-030 With back-to-back valid pairs and out_ready_in held at 1, the minimum evaluation period SHALL be NUM_INPUTS + 4 cycles.
REQ-031 result_out SHALL retain its last value after the handshake until the next SATURATE.

Reset
REQ-032 rst_in=1 at a clock edge SHALL force state IDLE, accumulator 0, counter 0 and result_out 0.
REQ-033 Reset SHALL force in_ready_out=0, out_valid_out=0 and busy_out=0 on the next cycle.
REQ-034 Reset asserted mid-evaluation SHALL abandon the evaluation with no output produced.
REQ-035 rst_in SHALL dominate start_in and all handshakes in the same cycle.

Structure
REQ-036 The FSM state enum and a helper function computing the minimum ACC_WIDTH SHALL live in shared package nn_pkg.
REQ-037 The block SHALL instantiate exactly one overflow_underflow_rectifier, with unrectified width ACC_WIDTH and rectified width DATA_WIDTH.
REQ-038 The counter SHALL be clog2(NUM_INPUTS+1) bits wide.

Verification (DATA_WIDTH=16, FRAC_BITS=8, NUM_INPUTS=4, ACC_WIDTH=40)
REQ-039 Nominal: bias=0x0100; four pairs of input=0x0200, weight=0x0080 -> result_out=0x0500, out_valid_out exactly 3 cycles after the 4th accept.
REQ-040 Positive saturation: bias=0x7000; four pairs of 0x7FFF*0x7FFF -> result_out=0x7FFF.
REQ-041 Negative saturation: bias=0x8000; four pairs of 0x8000*0x7FFF -> result_out=0x8000.
REQ-042 Stalls and backpressure: in_valid_in toggling 1,0,0,1 and out_ready_in held at 0 for 5 cycles -> same result as the no-stall run, and result_out stable throughout the wait.
REQ-043 Reset mid-operation: rst_in pulsed after 2 pairs -> next cycle busy_out=0, result_out=0; a following nominal run is correct.
REQ-044 Ignored start: start_in held at 1 through the whole evaluation -> only one evaluation runs, then a new one starts from IDLE.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neural-datapath definitions: controller state encoding and
// accumulator sizing helper.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SCALE,
        SATURATE,
        OUTPUT
    } state_t;

    // Smallest accumulator that holds a bias plus num_inputs full-precision products.
    function automatic int min_acc_width(input int data_width, input int num_inputs);
        return 2 * data_width + $clog2(num_inputs);
    endfunction

endpackage

// File: rtl/overflow_underflow_rectifier.sv
// Combinational signed clamp from UNRECT_WIDTH down to RECT_WIDTH bits,
// saturating to the most positive / most negative representable value.
module overflow_underflow_rectifier #(
    parameter int UNRECT_WIDTH = 40,
    parameter int RECT_WIDTH   = 16
) (
    input  logic signed [UNRECT_WIDTH-1:0] unrectified,
    output logic signed [RECT_WIDTH-1:0]   rectified
);

    logic fits;

    // The value fits when every bit above the target sign bit copies it.
    assign fits = (&unrectified[UNRECT_WIDTH-1:RECT_WIDTH-1]) |
                  (~|unrectified[UNRECT_WIDTH-1:RECT_WIDTH-1]);

    always_comb begin
        rectified = unrectified[RECT_WIDTH-1:0];
        if (!fits) begin
            if (unrectified[UNRECT_WIDTH-1])
                rectified = {1'b1, {(RECT_WIDTH-1){1'b0}}};
            else
                rectified = {1'b0, {(RECT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_mac_controller.sv
// Fixed-point neuron: bias + sum(input*weight) over NUM_INPUTS handshaked pairs,
// rescaled by FRAC_BITS and saturated to DATA_WIDTH.
module neuron_mac_controller
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int NUM_INPUTS = 8,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    input  logic                         in_valid_in,
    output logic                         in_ready_out,
    input  logic signed [DATA_WIDTH-1:0] input_in,
    input  logic signed [DATA_WIDTH-1:0] weight_in,
    output logic                         out_valid_out,
    input  logic                         out_ready_in,
    output logic signed [DATA_WIDTH-1:0] result_out,
    output logic                         busy_out
);

    localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;

    if (ACC_WIDTH < min_acc_width(DATA_WIDTH, NUM_INPUTS)) begin : g_acc_width_check
        $error("ACC_WIDTH too small for DATA_WIDTH/NUM_INPUTS");
    end

    state_t                        state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   scaled;
    logic        [CNT_W-1:0]       cnt;
    logic signed [PROD_W-1:0]      product;
    logic signed [DATA_WIDTH-1:0]  clamped;
    logic                          accept;

    assign product = input_in * weight_in;
    assign accept  = in_valid_in && in_ready_out;

    overflow_underflow_rectifier #(
        .UNRECT_WIDTH (ACC_WIDTH),
        .RECT_WIDTH   (DATA_WIDTH)
    ) u_rectifier (
        .unrectified (scaled),
        .rectified   (clamped)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            acc           <= '0;
            scaled        <= '0;
            cnt           <= '0;
            result_out    <= '0;
            in_ready_out  <= 1'b0;
            out_valid_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        acc          <= ACC_WIDTH'(bias_in) <<< FRAC_BITS;
                        cnt          <= '0;
                        in_ready_out <= 1'b1;
                        busy_out     <= 1'b1;
                        state        <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + ACC_WIDTH'(product);
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(NUM_INPUTS - 1)) begin
                            in_ready_out <= 1'b0;
                            state        <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    scaled <= acc >>> FRAC_BITS;
                    state  <= SATURATE;
                end
                SATURATE: begin
                    result_out    <= clamped;
                    out_valid_out <= 1'b1;
                    state         <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready_in) begin
                        out_valid_out <= 1'b0;
                        busy_out      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    in_ready_out  <= 1'b0;
                    out_valid_out <= 1'b0;
                    busy_out      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_controller.sv
// Directed bench for neuron_mac_controller with DATA_WIDTH=16, FRAC_BITS=8,
// NUM_INPUTS=4, ACC_WIDTH=40; inputs driven and outputs sampled on negedge.
module tb_neuron_mac_controller;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [DW-1:0] bias = '0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] w = '0;
    logic [DW-1:0] result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_mac_controller #(
        .DATA_WIDTH (16),
        .ACC_WIDTH  (40),
        .NUM_INPUTS (4),
        .FRAC_BITS  (8)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_in      (start),
        .bias_in       (bias),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .input_in      (a),
        .weight_in     (w),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .result_out    (result),
        .busy_out      (busy)
    );

    // Stimulus helpers (all entered and left on a negedge).
    task automatic start_eval(input logic [DW-1:0] b, input logic hold_start);
        @(negedge clk);
        start = 1'b1;
        bias  = b;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] x, input logic [DW-1:0] y, input int gaps);
        in_valid = 1'b1;
        a = x;
        w = y;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD;
        w = 16'hBEEF;
        for (int g = 0; g < gaps; g++) @(negedge clk);
    endtask

    task automatic wait_output(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b in_ready=%b out_valid=%b expected 0 0 0",
                     busy, in_ready, out_valid);
        end
        checks++;
        if (result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_result: got %h expected 0000", result);
        end
    endtask

    task automatic test_nominal;
        int lat;
        start_eval(16'h0100, 1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL nominal_accum_entry: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        for (int i = 0; i < 4; i++) feed(16'h0200, 16'h0080, 0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL nominal_scale_flags: in_ready=%b out_valid=%b expected 0 0",
                     in_ready, out_valid);
        end
        wait_output(lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL nominal_latency: got %0d expected 3", lat);
        end
        checks++;
        if (result !== 16'h0500) begin
            failures++;
            $display("FAIL nominal_result: got %h expected 0500", result);
        end
        handshake();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0500) begin
            failures++;
            $display("FAIL nominal_after_handshake: busy=%b out_valid=%b result=%h expected 0 0 0500",
                     busy, out_valid, result);
        end
    endtask

    task automatic test_pos_saturation;
        int lat;
        start_eval(16'h7000, 1'b0);
        for (int i = 0; i < 4; i++) feed(16'h7FFF, 16'h7FFF, 0);
        wait_output(lat);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h7FFF) begin
            failures++;
            $display("FAIL pos_saturation: valid=%b got %h expected 7fff", out_valid, result);
        end
        handshake();
    endtask

    task automatic test_neg_saturation;
        int lat;
        start_eval(16'h8000, 1'b0);
        for (int i = 0; i < 4; i++) feed(16'h8000, 16'h7FFF, 0);
        wait_output(lat);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h8000) begin
            failures++;
            $display("FAIL neg_saturation: valid=%b got %h expected 8000", out_valid, result);
        end
        handshake();
    endtask

    task automatic test_stall_backpressure;
        int lat;
        start_eval(16'h0100, 1'b0);
        // in_valid pattern 1,0,0,1 then two more pairs
        feed(16'h0200, 16'h0080, 2);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: in_ready=%b busy=%b out_valid=%b expected 1 1 0",
                     in_ready, busy, out_valid);
        end
        for (int i = 0; i < 3; i++) feed(16'h0200, 16'h0080, 0);
        wait_output(lat);
        checks++;
        if (lat !== 3 || result !== 16'h0500) begin
            failures++;
            $display("FAIL stall_result: lat=%0d result=%h expected 3 0500", lat, result);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 16'h0500) begin
                failures++;
                $display("FAIL backpressure_hold: cycle=%0d valid=%b result=%h expected 1 0500",
                         c, out_valid, result);
            end
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        start_eval(16'h0100, 1'b0);
        feed(16'h0200, 16'h0080, 0);
        feed(16'h0200, 16'h0080, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid: busy=%b in_ready=%b valid=%b result=%h expected 0 0 0 0000",
                     busy, in_ready, out_valid, result);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_output: valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        start_eval(16'h0100, 1'b0);
        for (int i = 0; i < 4; i++) feed(16'h0200, 16'h0080, 0);
        wait_output(lat);
        checks++;
        if (lat !== 3 || result !== 16'h0500) begin
            failures++;
            $display("FAIL reset_mid_rerun: lat=%0d result=%h expected 3 0500", lat, result);
        end
        handshake();
    endtask

    task automatic test_ignored_start;
        int lat;
        start_eval(16'h0100, 1'b1);
        for (int i = 0; i < 4; i++) feed(16'h0200, 16'h0080, 0);
        wait_output(lat);
        checks++;
        if (lat !== 3 || result !== 16'h0500) begin
            failures++;
            $display("FAIL ignored_start_result: lat=%0d result=%h expected 3 0500", lat, result);
        end
        // Second evaluation: bias 0, four products of -1 -> -4/256 floors to -1.
        bias = 16'h0000;
        handshake();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_idle: busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ignored_start_restart: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        for (int i = 0; i < 4; i++) feed(16'h0001, 16'hFFFF, 0);
        wait_output(lat);
        checks++;
        if (lat !== 3 || result !== 16'hFFFF) begin
            failures++;
            $display("FAIL ignored_start_second: lat=%0d result=%h expected 3 ffff", lat, result);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pos_saturation();
        test_neg_saturation();
        test_stall_backpressure();
        test_reset_mid();
        test_ignored_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
